// File: rtl/iiitb_rv32i_mem_arb.sv
// Shares one single-port memory between rv32i fetch (IF) and data (D) requesters.
// Define IIITB_ARB_PERF_EN to add the perf_if_wait / perf_d_wait wait-cycle counters.
module iiitb_rv32i_mem_arb #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          RN,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
`ifdef IIITB_ARB_PERF_EN
   ,
   output logic [31:0]   perf_if_wait,
   output logic [31:0]   perf_d_wait
`endif
);

   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t        r_state;
   logic          r_win_d;
   logic [LW-1:0] r_lat;
   logic [SW-1:0] r_starve;
   logic          r_if_ack, r_d_ack, r_mem_en, r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
   logic          w_busy, w_pick_d;

   assign w_busy   = (r_state != S_IDLE);
   // D wins unless IF has already been passed over STARVE_MAX times in a row
   assign w_pick_d = d_req && (!if_req || (r_starve < SW'(STARVE_MAX)));

   always_ff @(posedge clk or posedge RN) begin
      if (RN) begin
         r_state     <= S_IDLE;
         r_win_d     <= 1'b0;
         r_lat       <= '0;
         r_starve    <= '0;
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
         r_mem_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick_d) begin
                  r_win_d     <= 1'b1;
                  r_mem_we    <= d_we;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
                  r_mem_en    <= 1'b1;
                  r_state     <= S_ISSUE;
                  if (if_req) r_starve <= r_starve + 1'b1;
               end else if (if_req) begin
                  r_win_d    <= 1'b0;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= if_addr;
                  r_mem_en   <= 1'b1;
                  r_starve   <= '0;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_lat   <= LW'(MEM_LAT - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_lat == '0) begin
                  if (r_win_d) begin
                     if (!r_mem_we) r_d_rdata <= mem_rdata;
                     r_d_ack <= 1'b1;
                  end else begin
                     r_if_rdata <= mem_rdata;
                     r_if_ack   <= 1'b1;
                  end
                  r_state <= S_DONE;
               end else begin
                  r_lat <= r_lat - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_ack    = r_if_ack;
   assign if_rdata  = r_if_rdata;
   assign d_ack     = r_d_ack;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = w_busy;

`ifdef IIITB_ARB_PERF_EN
   logic [31:0] r_perf_if, r_perf_d;
   logic        w_if_wait, w_d_wait;

   // A requester is waiting only while the other side owns the memory
   assign w_if_wait = if_req && w_busy && r_win_d;
   assign w_d_wait  = d_req && w_busy && !r_win_d;

   always_ff @(posedge clk or posedge RN) begin
      if (RN) begin
         r_perf_if <= '0;
         r_perf_d  <= '0;
      end else begin
         if (w_if_wait && (r_perf_if != 32'hFFFF_FFFF)) r_perf_if <= r_perf_if + 32'd1;
         if (w_d_wait && (r_perf_d != 32'hFFFF_FFFF))   r_perf_d  <= r_perf_d + 32'd1;
      end
   end

   assign perf_if_wait = r_perf_if;
   assign perf_d_wait  = r_perf_d;
`endif

endmodule

// File: doc/iiitb_rv32i_mem_arb.md
Name: iiitb_rv32i_mem_arb

Overview:
Arbiter and sequencer that shares one single-port memory between the rv32i core's instruction-fetch requester (IF) and data requester (D, load/store stage). It sits between iiitb_rv32i and the memory macro. It grants one access at a time under fixed data-first priority with an IF starvation guard, drives the memory strobes, waits the fixed memory latency, then returns read data with a one-cycle ack.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, cycles from mem_en pulse to mem_rdata valid (legal range >=1)
STARVE_MAX, 3, consecutive D grants allowed while IF is pending before IF is forced

Ports:
clk  in  1  clock, rising edge
RN  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  AW  fetch address, stable while if_req high
if_ack  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DW  fetch data, held until next if_ack
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle pulse, load data valid / store done
d_rdata  out  DW  load data, held until next d_ack
mem_en  out  1  one-cycle access strobe
mem_we  out  1  write enable, only with mem_en
mem_addr  out  AW  memory address, held through access
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (RN=1, async): state=IDLE; all outputs 0; starve_cnt=0; the in-flight access is dropped and no ack is issued for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests are sampled at a clock edge. If any req is high, latch the winner, mem_addr, mem_wdata and mem_we (d_we for D, 0 for IF), then go to ISSUE. Otherwise stay in IDLE.
- Priority when both requests are high:
  - D wins while starve_cnt < STARVE_MAX; starve_cnt increments.
  - IF wins when starve_cnt == STARVE_MAX.
  - starve_cnt clears on every IF grant.
  - A D grant with if_req low leaves starve_cnt unchanged.
- ISSUE: mem_en=1 for exactly this cycle. Load the latency counter with MEM_LAT-1, then go to WAIT.
- WAIT: decrement the counter. At count 0, capture mem_rdata into the winner's rdata register (loads and fetches only; d_rdata is unchanged on stores) and go to DONE.
- DONE: the winner's ack=1 for one cycle, then go to IDLE. The other ack stays 0.
- Latency: req sampled at edge t → mem_en high in cycle t..t+1 → ack high in cycle t+MEM_LAT+1..t+MEM_LAT+2. The IDLE slot between transactions is mandatory.
- Requester contract:
  - Drop req at the edge after ack is seen; the arbiter is in IDLE then and does not re-grant.
  - A req still high one cycle after ack is treated as a new request.
  - Address and data must be stable while req is high; changes before ack are ignored (already latched).
- mem_addr, mem_wdata and mem_we hold their last values in IDLE. mem_we is only meaningful while mem_en=1.
- Simultaneous requests arriving while busy: no queuing beyond the level req. Priority is evaluated at the next IDLE.

Optional Feature:
IIITB_ARB_PERF_EN:
- Defined: adds outputs perf_if_wait[31:0] and perf_d_wait[31:0].
  - Each counts cycles where its req=1 and that requester is not the current winner in ISSUE/WAIT/DONE.
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0 on RN.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x0000_0010, mem returns 0x0050_0093 → mem_en one cycle, mem_we=0; if_ack at edge t+3 (MEM_LAT=2); if_rdata=0x0050_0093; d_ack stays 0.
- Store then load: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF → mem_we=1 with mem_en, d_ack after 3 cycles, d_rdata unchanged. Then load 0x100 → d_rdata=0xDEAD_BEEF.
- Contention: both reqs held continuously, STARVE_MAX=3 → grant order D,D,D,IF,D,D,D,IF; no IF wait exceeds 3 D transactions.
- Reset mid-op: assert RN during WAIT of a D load → next cycle all outputs 0, no d_ack; after release, a new if_req completes normally.
- Late req drop: hold d_req one extra cycle after d_ack → a second D access is issued (two mem_en pulses, two d_acks).
- With IIITB_ARB_PERF_EN: both reqs asserted from cycle 0, D granted first, MEM_LAT=2 → perf_if_wait=4 when IF enters ISSUE; perf_d_wait=0.
